// File: rtl/merge_wr_sched.sv
// merge_wr_sched
//   Write-side scheduler for the 9-lane transactor interface. Nine 9-bit write
//   lanes are captured into per-lane holding slots, then a round-robin arbiter
//   moves one slot per cycle into a tagged first-word-fall-through FIFO.
//   freeze_clk asks upstream to stop its clock whenever more lane writes are
//   pending than can be absorbed on the next edge.
//
// Ports
//   clk         : clock; every register updates on its rising edge
//   reset_n     : asynchronous, active-low reset
//   wen[8:0]    : per-lane write strobe; bit k qualifies i_datak
//   i_data0..8  : lane write data, 9 bits each
//   ren         : read strobe; pops the head entry when valid=1
//   valid       : FIFO non-empty
//   o_data      : head entry data (0 when empty)
//   o_src       : head entry lane index 0..8 (0 when empty)
//   freeze_clk  : registered request to stop the upstream clock
module merge_wr_sched #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [8:0] wen,
  input  logic [8:0] i_data0,
  input  logic [8:0] i_data1,
  input  logic [8:0] i_data2,
  input  logic [8:0] i_data3,
  input  logic [8:0] i_data4,
  input  logic [8:0] i_data5,
  input  logic [8:0] i_data6,
  input  logic [8:0] i_data7,
  input  logic [8:0] i_data8,
  input  logic       ren,
  output logic       valid,
  output logic [8:0] o_data,
  output logic [3:0] o_src,
  output logic       freeze_clk
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [8:0]  lane_data [9];
  logic [8:0]  hold_q    [9];
  logic [8:0]  pend_q, pend_d;
  logic [3:0]  rr_ptr_q, rr_ptr_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q, count_d;
  logic        freeze_q, freeze_d;
  logic [12:0] mem_q [DEPTH];

  logic [8:0]  cap;
  logic        full;
  logic        grant_vld;
  logic [3:0]  grant_idx;
  logic [8:0]  grant_oh;
  logic        push, pop;
  logic [3:0]  npend;
  logic [12:0] head;

  assign lane_data[0] = i_data0;
  assign lane_data[1] = i_data1;
  assign lane_data[2] = i_data2;
  assign lane_data[3] = i_data3;
  assign lane_data[4] = i_data4;
  assign lane_data[5] = i_data5;
  assign lane_data[6] = i_data6;
  assign lane_data[7] = i_data7;
  assign lane_data[8] = i_data8;

  // Upstream is stopped while frozen, so its strobes are meaningless then.
  assign cap  = freeze_q ? 9'd0 : wen;
  assign full = (count_q == FULL_CNT);

  // Round-robin search: walk offsets from high to low so the candidate
  // closest to rr_ptr (lowest offset) is the one left standing.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 4'd0;
    for (int off = 8; off >= 0; off--) begin
      logic [4:0] cand;
      cand = {1'b0, rr_ptr_q} + 5'(off);
      if (cand >= 5'd9) cand = cand - 5'd9;
      if (pend_q[cand[3:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[3:0];
      end
    end
    // Full is judged on the pre-edge count; a same-cycle pop does not help.
    if (full) grant_vld = 1'b0;
  end

  assign grant_oh = grant_vld ? (9'd1 << grant_idx) : 9'd0;
  assign push     = grant_vld;
  assign pop      = ren && valid;

  always_comb begin
    // Capture is OR-ed after the clear so a same-lane capture wins over the
    // grant; the FIFO still receives the old hold value this edge.
    pend_d   = (pend_q & ~grant_oh) | cap;
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) rr_ptr_d = (grant_idx == 4'd8) ? 4'd0 : grant_idx + 4'd1;
    count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    npend    = 4'd0;
    for (int i = 0; i < 9; i++) npend = npend + 4'(pend_d[i]);
    freeze_d = (npend >= 4'd2) || ((pend_d != 9'd0) && (count_d == FULL_CNT));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q   <= '0;
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      freeze_q <= 1'b0;
      for (int i = 0; i < 9; i++) hold_q[i] <= '0;
    end else begin
      pend_q   <= pend_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      freeze_q <= freeze_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      for (int i = 0; i < 9; i++)
        if (cap[i]) hold_q[i] <= lane_data[i];
    end
  end

  // Storage is not reset: contents are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {grant_idx, hold_q[grant_idx]};
  end

  assign head       = mem_q[rd_ptr_q];
  assign valid      = (count_q != '0);
  assign o_data     = valid ? head[8:0]  : 9'd0;
  assign o_src      = valid ? head[12:9] : 4'd0;
  assign freeze_clk = freeze_q;

endmodule

// File: tb/tb_merge_wr_sched.sv
// tb_merge_wr_sched
//   Scenario-driven bench for merge_wr_sched. Expected FIFO entries
//   ({src, data}) are queued when the lane writes are driven and compared
//   against o_src/o_data when the DUT presents them on a read.
module tb_merge_wr_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [8:0] wen;
  logic [8:0] din [9];
  logic       ren;
  logic       valid;
  logic [8:0] o_data;
  logic [3:0] o_src;
  logic       freeze_clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [12:0] sb [$];
  logic [12:0] exp_e;

  always #5 clk = ~clk;

  merge_wr_sched #(.DEPTH(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wen        (wen),
    .i_data0    (din[0]),
    .i_data1    (din[1]),
    .i_data2    (din[2]),
    .i_data3    (din[3]),
    .i_data4    (din[4]),
    .i_data5    (din[5]),
    .i_data6    (din[6]),
    .i_data7    (din[7]),
    .i_data8    (din[8]),
    .ren        (ren),
    .valid      (valid),
    .o_data     (o_data),
    .o_src      (o_src),
    .freeze_clk (freeze_clk)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    wen = 9'd0;
    ren = 1'b0;
    for (int k = 0; k < 9; k++) din[k] = 9'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    sb.delete();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    #3;
    tests_run++;
    if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, required 0", valid); end
    tests_run++;
    if (o_data !== 9'd0) begin tests_failed++; $display("FAIL reset_o_data: got %h, required 000", o_data); end
    tests_run++;
    if (o_src !== 4'd0) begin tests_failed++; $display("FAIL reset_o_src: got %0d, required 0", o_src); end
    tests_run++;
    if (freeze_clk !== 1'b0) begin tests_failed++; $display("FAIL reset_freeze: got %b, required 0", freeze_clk); end
    tick();
    reset_n = 1'b1;
    tick();
    $display("[TB] test_reset done");
  endtask

  task automatic test_single_write();
    do_reset();
    wen = 9'h008; din[3] = 9'h1A5;
    sb.push_back({4'd3, 9'h1A5});
    tick();
    wen = 9'd0;
    @(negedge clk);
    tests_run++;
    if (valid !== 1'b0) begin tests_failed++; $display("FAIL single_early_valid: got %b, required 0", valid); end
    tick();
    @(negedge clk);
    tests_run++;
    if (valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %b, required 1", valid); end
    exp_e = sb.pop_front();
    tests_run++;
    if ({o_src, o_data} !== exp_e) begin
      tests_failed++;
      $display("FAIL single_data: got src=%0d data=%h, required src=%0d data=%h", o_src, o_data, exp_e[12:9], exp_e[8:0]);
    end
    tests_run++;
    if (freeze_clk !== 1'b0) begin tests_failed++; $display("FAIL single_freeze: got %b, required 0", freeze_clk); end
    tick();
    ren = 1'b1;
    tick();
    ren = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({valid, o_src, o_data} !== 14'd0) begin
      tests_failed++;
      $display("FAIL single_after_pop: got valid=%b src=%0d data=%h, required all 0", valid, o_src, o_data);
    end
    tick();
    $display("[TB] test_single_write done");
  endtask

  task automatic test_all_lane_burst();
    int fz;
    do_reset();
    wen = 9'h1FF;
    for (int k = 0; k < 9; k++) begin
      din[k] = 9'h100 + 9'(k);
      sb.push_back({4'(k), 9'h100 + 9'(k)});
    end
    tick();
    wen = 9'd0;
    fz = 0;
    repeat (20) begin
      @(negedge clk);
      if (freeze_clk === 1'b1) fz++;
      tick();
    end
    tests_run++;
    if (fz != 8) begin tests_failed++; $display("FAIL burst_freeze_cycles: got %0d, required 8", fz); end
    ren = 1'b1;
    for (int c = 0; c < 64 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        exp_e = sb.pop_front();
        tests_run++;
        if ({o_src, o_data} !== exp_e) begin
          tests_failed++;
          $display("FAIL burst_data: got src=%0d data=%h, required src=%0d data=%h", o_src, o_data, exp_e[12:9], exp_e[8:0]);
        end
      end
      tick();
    end
    ren = 1'b0;
    @(negedge clk);
    tests_run++;
    if (sb.size() != 0 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL burst_drain: got %0d missing, valid=%b, required 0 missing, valid=0", sb.size(), valid);
    end
    tick();
    $display("[TB] test_all_lane_burst done");
  endtask

  task automatic test_round_robin();
    int n;
    int got;
    do_reset();
    ren = 1'b1;
    n = 0;
    got = 0;
    for (int c = 0; c < 600 && (n < 50 || sb.size() > 0); c++) begin
      if (freeze_clk === 1'b0 && n < 50) begin
        wen = 9'h084;
        din[2] = 9'(n);
        din[7] = 9'h100 | 9'(n);
        sb.push_back({4'd2, 9'(n)});
        sb.push_back({4'd7, 9'h100 | 9'(n)});
        n++;
      end else begin
        wen = 9'd0;
      end
      @(negedge clk);
      if (valid === 1'b1 && sb.size() > 0) begin
        exp_e = sb.pop_front();
        got++;
        tests_run++;
        if ({o_src, o_data} !== exp_e) begin
          tests_failed++;
          $display("FAIL rr_data: entry %0d got src=%0d data=%h, required src=%0d data=%h", got, o_src, o_data, exp_e[12:9], exp_e[8:0]);
        end
      end
      tick();
    end
    wen = 9'd0;
    ren = 1'b0;
    tests_run++;
    if (got != 100) begin tests_failed++; $display("FAIL rr_count: got %0d entries, required 100", got); end
    @(negedge clk);
    tests_run++;
    if (valid !== 1'b0) begin tests_failed++; $display("FAIL rr_leftover: got valid=%b, required 0", valid); end
    tick();
    $display("[TB] test_round_robin done");
  endtask

  task automatic test_full_fifo();
    int bad_fz;
    int fz;
    do_reset();
    bad_fz = 0;
    for (int i = 0; i < 16; i++) begin
      if (freeze_clk !== 1'b0) bad_fz++;
      wen = 9'h001; din[0] = 9'h040 + 9'(i);
      sb.push_back({4'd0, 9'h040 + 9'(i)});
      tick();
    end
    if (freeze_clk !== 1'b0) bad_fz++;
    wen = 9'h020; din[5] = 9'h155;
    sb.push_back({4'd5, 9'h155});
    tick();
    wen = 9'd0;
    tests_run++;
    if (bad_fz != 0) begin tests_failed++; $display("FAIL full_fill_freeze: got %0d frozen cycles, required 0", bad_fz); end
    fz = 0;
    repeat (5) begin
      @(negedge clk);
      if (freeze_clk === 1'b1 && valid === 1'b1) fz++;
      tick();
    end
    tests_run++;
    if (fz != 5) begin tests_failed++; $display("FAIL full_hold_freeze: got %0d frozen cycles, required 5", fz); end
    ren = 1'b1;
    @(negedge clk);
    exp_e = sb.pop_front();
    tests_run++;
    if ({o_src, o_data} !== exp_e) begin
      tests_failed++;
      $display("FAIL full_head: got src=%0d data=%h, required src=%0d data=%h", o_src, o_data, exp_e[12:9], exp_e[8:0]);
    end
    tick();
    ren = 1'b0;
    @(negedge clk);
    tests_run++;
    if (freeze_clk !== 1'b0) begin tests_failed++; $display("FAIL full_unfreeze: got %b, required 0", freeze_clk); end
    tick();
    ren = 1'b1;
    for (int c = 0; c < 64 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        exp_e = sb.pop_front();
        tests_run++;
        if ({o_src, o_data} !== exp_e) begin
          tests_failed++;
          $display("FAIL full_data: got src=%0d data=%h, required src=%0d data=%h", o_src, o_data, exp_e[12:9], exp_e[8:0]);
        end
      end
      tick();
    end
    ren = 1'b0;
    @(negedge clk);
    tests_run++;
    if (sb.size() != 0 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_drain: got %0d missing, valid=%b, required 0 missing, valid=0", sb.size(), valid);
    end
    tick();
    $display("[TB] test_full_fifo done");
  endtask

  task automatic test_back_to_back();
    int fz;
    do_reset();
    fz = 0;
    wen = 9'h010; din[4] = 9'h011;
    sb.push_back({4'd4, 9'h011});
    tick();
    din[4] = 9'h022;
    sb.push_back({4'd4, 9'h022});
    tick();
    wen = 9'd0;
    ren = 1'b1;
    for (int c = 0; c < 32 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (freeze_clk !== 1'b0) fz++;
      if (valid === 1'b1) begin
        exp_e = sb.pop_front();
        tests_run++;
        if ({o_src, o_data} !== exp_e) begin
          tests_failed++;
          $display("FAIL b2b_data: got src=%0d data=%h, required src=%0d data=%h", o_src, o_data, exp_e[12:9], exp_e[8:0]);
        end
      end
      tick();
    end
    ren = 1'b0;
    tests_run++;
    if (fz != 0) begin tests_failed++; $display("FAIL b2b_freeze: got %0d frozen cycles, required 0", fz); end
    @(negedge clk);
    tests_run++;
    if (sb.size() != 0 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_drain: got %0d missing, valid=%b, required 0 missing, valid=0", sb.size(), valid);
    end
    tick();
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    wen = 9'h1FF;
    for (int k = 0; k < 9; k++) din[k] = 9'h100 + 9'(k);
    tick();
    wen = 9'd0;
    repeat (3) tick();
    @(negedge clk);
    tests_run++;
    if (freeze_clk !== 1'b1) begin tests_failed++; $display("FAIL midrst_pre_freeze: got %b, required 1", freeze_clk); end
    #1;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({freeze_clk, valid, o_src, o_data} !== 15'd0) begin
      tests_failed++;
      $display("FAIL midrst_async: got freeze=%b valid=%b src=%0d data=%h, required all 0", freeze_clk, valid, o_src, o_data);
    end
    sb.delete();
    tick();
    reset_n = 1'b1;
    tick();
    wen = 9'h002; din[1] = 9'h0AB;
    sb.push_back({4'd1, 9'h0AB});
    tick();
    wen = 9'd0;
    ren = 1'b1;
    for (int c = 0; c < 16 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        exp_e = sb.pop_front();
        tests_run++;
        if ({o_src, o_data} !== exp_e) begin
          tests_failed++;
          $display("FAIL midrst_data: got src=%0d data=%h, required src=%0d data=%h", o_src, o_data, exp_e[12:9], exp_e[8:0]);
        end
      end
      tick();
    end
    ren = 1'b0;
    @(negedge clk);
    tests_run++;
    if (sb.size() != 0 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_drain: got %0d missing, valid=%b, required 0 missing, valid=0", sb.size(), valid);
    end
    tick();
    $display("[TB] test_reset_mid_burst done");
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_write();
    test_all_lane_burst();
    test_round_robin();
    test_full_fifo();
    test_back_to_back();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
